// File: rtl/guess_entry_ctrl.sv
// Digit-entry controller for a number-guessing game: edits a 5-digit guess,
// hands it to an external judge, and tracks wrong tries and the cursor blink.
module guess_entry_ctrl #(
   parameter int BLINK_HALF = 25000000,
   parameter int MAX_TRIES  = 7
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_inc,
   input  logic        btn_dec,
   input  logic        btn_submit,
   input  logic        result_valid,
   input  logic [1:0]  result,
   output logic [16:0] databuffer,
   output logic [2:0]  i,
   output logic        blink,
   output logic        guess_valid,
   output logic [3:0]  tries,
   output logic        win,
   output logic        lose
);

   typedef enum logic [1:0] {EDIT, REQ, WIN, LOSE} state_t;

   localparam int CW = (2 * BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * BLINK_HALF - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(BLINK_HALF);

   state_t        state;
   logic [CW-1:0] blink_cnt;
   logic [CW-1:0] cnt_next;
   logic          edit_act;

   // Digit 4 is a single bit that toggles; digits 0..3 wrap within BCD with no carry.
   function automatic logic [16:0] step_digit(input logic [16:0] db_in,
                                              input logic [2:0]  idx,
                                              input logic        up);
      logic [16:0] r;
      logic [3:0]  d;
      r = db_in;
      if (idx == 3'd4) begin
         r[16] = ~db_in[16];
      end else begin
         d = db_in[{idx[1:0], 2'b00} +: 4];
         if (up) d = (d == 4'd9) ? 4'd0 : d + 4'd1;
         else    d = (d == 4'd0) ? 4'd9 : d - 4'd1;
         r[{idx[1:0], 2'b00} +: 4] = d;
      end
      return r;
   endfunction

   // An accepted edit restarts the blink so the touched digit starts blanked.
   assign edit_act = (state == EDIT) && !btn_submit &&
                     (btn_inc || btn_dec || btn_left || btn_right);
   assign cnt_next = (edit_act || blink_cnt == CNT_LAST) ? '0 : blink_cnt + 1'b1;

   // NOTE: all state and outputs update with non-blocking assignments so every
   // right-hand side sees the pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= EDIT;
         databuffer  <= '0;
         i           <= '0;
         tries       <= '0;
         blink_cnt   <= '0;
         blink       <= 1'b0;
         guess_valid <= 1'b0;
         win         <= 1'b0;
         lose        <= 1'b0;
      end else begin
         blink_cnt <= cnt_next;
         blink     <= (cnt_next >= CNT_HALF);
         case (state)
            EDIT: begin
               if (btn_submit) begin
                  state       <= REQ;
                  guess_valid <= 1'b1;
               end else if (btn_inc) begin
                  databuffer <= step_digit(databuffer, i, 1'b1);
               end else if (btn_dec) begin
                  databuffer <= step_digit(databuffer, i, 1'b0);
               end else if (btn_left) begin
                  i <= (i == 3'd4) ? 3'd0 : i + 3'd1;
               end else if (btn_right) begin
                  i <= (i == 3'd0) ? 3'd4 : i - 3'd1;
               end
            end
            REQ: begin
               if (result_valid) begin
                  guess_valid <= 1'b0;
                  if (result == 2'b10) begin
                     state <= WIN;
                     win   <= 1'b1;
                  end else begin
                     tries <= tries + 4'd1;
                     if ((tries + 4'd1) == 4'(MAX_TRIES)) begin
                        state <= LOSE;
                        lose  <= 1'b1;
                     end else begin
                        state <= EDIT;
                     end
                  end
               end
            end
            WIN, LOSE: begin
               if (btn_submit) begin
                  state      <= EDIT;
                  win        <= 1'b0;
                  lose       <= 1'b0;
                  databuffer <= '0;
                  i          <= '0;
                  tries      <= '0;
               end
            end
            default: state <= EDIT;
         endcase
      end
   end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Self-checking bench for guess_entry_ctrl: directed scenarios followed by
// randomized traffic compared against a digit-array reference model.
module tb_guess_entry_ctrl;

   localparam int HALF = 4;
   localparam int MAXT = 2;
   localparam int S_EDIT = 0, S_REQ = 1, S_WIN = 2, S_LOSE = 3;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        btn_left = 1'b0, btn_right = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
   logic        btn_submit = 1'b0, result_valid = 1'b0;
   logic [1:0]  result = 2'b00;
   logic [16:0] databuffer;
   logic [2:0]  i;
   logic        blink, guess_valid, win, lose;
   logic [3:0]  tries;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, kept as plain integers
   int m_state, m_cur, m_tries, m_bcnt;
   int dig [5];

   guess_entry_ctrl #(.BLINK_HALF(HALF), .MAX_TRIES(MAXT)) dut (
      .CLK(CLK), .RST(RST),
      .btn_left(btn_left), .btn_right(btn_right), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .btn_submit(btn_submit), .result_valid(result_valid), .result(result),
      .databuffer(databuffer), .i(i), .blink(blink), .guess_valid(guess_valid),
      .tries(tries), .win(win), .lose(lose)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      bit touched;
      touched = 1'b0;
      if (RST) begin
         m_state = S_EDIT; m_cur = 0; m_tries = 0; m_bcnt = 0;
         for (int k = 0; k < 5; k++) dig[k] = 0;
      end else begin
         case (m_state)
            S_EDIT: begin
               if (btn_submit) m_state = S_REQ;
               else if (btn_inc) begin
                  dig[m_cur] = (m_cur == 4) ? 1 - dig[4] : (dig[m_cur] + 1) % 10;
                  touched = 1'b1;
               end else if (btn_dec) begin
                  dig[m_cur] = (m_cur == 4) ? 1 - dig[4] : (dig[m_cur] + 9) % 10;
                  touched = 1'b1;
               end else if (btn_left) begin
                  m_cur = (m_cur + 1) % 5;
                  touched = 1'b1;
               end else if (btn_right) begin
                  m_cur = (m_cur + 4) % 5;
                  touched = 1'b1;
               end
            end
            S_REQ: begin
               if (result_valid) begin
                  if (result == 2'b10) m_state = S_WIN;
                  else begin
                     m_tries++;
                     m_state = (m_tries == MAXT) ? S_LOSE : S_EDIT;
                  end
               end
            end
            default: begin
               if (btn_submit) begin
                  m_state = S_EDIT; m_cur = 0; m_tries = 0;
                  for (int k = 0; k < 5; k++) dig[k] = 0;
               end
            end
         endcase
         m_bcnt = touched ? 0 : (m_bcnt + 1) % (2 * HALF);
      end
   endtask

   task automatic compare_all();
      int exp_db;
      exp_db = dig[4] * 65536 + dig[3] * 4096 + dig[2] * 256 + dig[1] * 16 + dig[0];
      check("databuffer",  {15'b0, databuffer},   exp_db);
      check("i",           {29'b0, i},            m_cur);
      check("blink",       {31'b0, blink},        (m_bcnt >= HALF) ? 1 : 0);
      check("guess_valid", {31'b0, guess_valid},  (m_state == S_REQ) ? 1 : 0);
      check("tries",       {28'b0, tries},        m_tries);
      check("win",         {31'b0, win},          (m_state == S_WIN) ? 1 : 0);
      check("lose",        {31'b0, lose},         (m_state == S_LOSE) ? 1 : 0);
   endtask

   // One clock: inputs already driven by the caller are sampled, then cleared.
   task automatic step();
      @(posedge CLK);
      model_update();
      #1;
      compare_all();
      RST = 0; btn_left = 0; btn_right = 0; btn_inc = 0; btn_dec = 0;
      btn_submit = 0; result_valid = 0; result = 2'b00;
   endtask

   logic [16:0] saved_db;

   initial begin
      m_state = S_EDIT; m_cur = 0; m_tries = 0; m_bcnt = 0;
      for (int k = 0; k < 5; k++) dig[k] = 0;
      #2;

      // Reset values
      RST = 1; step();
      check("rst_db", {15'b0, databuffer}, 0);
      check("rst_blink", {31'b0, blink}, 0);

      // Basic editing: 3 inc, left, 2 dec
      for (int k = 0; k < 3; k++) begin btn_inc = 1; step(); end
      btn_left = 1; step();
      for (int k = 0; k < 2; k++) begin btn_dec = 1; step(); end
      check("edit_db", {15'b0, databuffer}, 32'h00083);
      check("edit_i", {29'b0, i}, 1);

      // Cursor wrap and the single-bit top digit
      for (int k = 0; k < 3; k++) begin btn_left = 1; step(); end
      check("cur_at4", {29'b0, i}, 4);
      for (int k = 0; k < 2; k++) begin btn_left = 1; step(); end
      check("cur_wrap_left", {29'b0, i}, 1);
      btn_right = 1; step();
      btn_right = 1; step();
      check("cur_wrap_right", {29'b0, i}, 4);
      btn_inc = 1; step();
      check("bit16_set", {31'b0, databuffer[16]}, 1);
      btn_inc = 1; step();
      check("bit16_clr", {31'b0, databuffer[16]}, 0);

      // Free-running blink from a fresh reset, then restart on an edit
      RST = 1; step();
      for (int k = 1; k <= 16; k++) begin
         step();
         check("blink_free", {31'b0, blink}, ((k % 8) >= HALF) ? 1 : 0);
      end
      for (int k = 0; k < 5; k++) step();
      check("blink_high", {31'b0, blink}, 1);
      btn_inc = 1; step();
      check("blink_restart", {31'b0, blink}, 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         check("blink_return", {31'b0, blink}, (k == 4) ? 1 : 0);
      end

      // Submit, hold the request while buttons chatter, then win
      btn_submit = 1; step();
      check("req_gv", {31'b0, guess_valid}, 1);
      saved_db = databuffer;
      for (int k = 0; k < 5; k++) begin
         btn_inc = k[0]; btn_dec = ~k[0]; btn_left = 1; btn_submit = k[1];
         step();
         check("req_hold_gv", {31'b0, guess_valid}, 1);
         check("req_hold_db", {15'b0, databuffer}, {15'b0, saved_db});
      end
      result_valid = 1; result = 2'b10; step();
      check("win", {31'b0, win}, 1);
      check("win_gv", {31'b0, guess_valid}, 0);
      btn_submit = 1; step();
      check("win_restart_db", {15'b0, databuffer}, 0);

      // Two wrong guesses reach LOSE; result_valid outside REQ is ignored
      btn_inc = 1; step();
      btn_submit = 1; step();
      result_valid = 1; result = 2'b00; step();
      check("tries1", {28'b0, tries}, 1);
      check("tries1_db", {15'b0, databuffer}, 1);
      result_valid = 1; result = 2'b10; step();
      check("ignore_rv_edit", {31'b0, win}, 0);
      btn_submit = 1; step();
      result_valid = 1; result = 2'b11; step();
      check("lose", {31'b0, lose}, 1);
      check("lose_tries", {28'b0, tries}, 2);
      btn_submit = 1; step();
      check("lose_restart_tries", {28'b0, tries}, 0);
      check("lose_restart_lose", {31'b0, lose}, 0);

      // Submit beats inc; reset during REQ discards a coincident result
      btn_inc = 1; step();
      btn_submit = 1; btn_inc = 1; step();
      check("prio_gv", {31'b0, guess_valid}, 1);
      check("prio_db", {15'b0, databuffer}, 1);
      RST = 1; result_valid = 1; result = 2'b10; step();
      check("rst_req_gv", {31'b0, guess_valid}, 0);
      check("rst_req_win", {31'b0, win}, 0);
      check("rst_req_db", {15'b0, databuffer}, 0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         btn_left     = ($urandom_range(0, 3) == 0);
         btn_right    = ($urandom_range(0, 3) == 0);
         btn_inc      = ($urandom_range(0, 3) == 0);
         btn_dec      = ($urandom_range(0, 3) == 0);
         btn_submit   = ($urandom_range(0, 4) == 0);
         result_valid = ($urandom_range(0, 3) == 0);
         result       = 2'($urandom_range(0, 3));
         RST          = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/guess_entry_ctrl.md
GUESS_ENTRY_CTRL -- requirements
Module: guess_entry_ctrl

Interface
REQ-001 Parameter: BLINK_HALF, default 25000000, cursor blink half-period in CLK cycles.
REQ-002 Parameter: MAX_TRIES, default 7, wrong guesses allowed before loss (range 1..15).
REQ-003 Port: CLK  input  1  system clock; all state on rising edge.
REQ-004 Port: RST  input  1  reset, synchronous, active-high.
REQ-005 Port: btn_left  input  1  one-cycle pulse; move cursor to more-significant digit.
REQ-006 Port: btn_right  input  1  one-cycle pulse; move cursor to less-significant digit.
REQ-007 Port: btn_inc  input  1  one-cycle pulse; increment digit under cursor.
REQ-008 Port: btn_dec  input  1  one-cycle pulse; decrement digit under cursor.
REQ-009 Port: btn_submit  input  1  one-cycle pulse; submit guess, or restart from WIN/LOSE.
REQ-010 Port: result_valid  input  1  judge response strobe.
REQ-011 Port: result  input  2  00 guess low, 01 guess high, 10 equal, 11 treated as 00.
REQ-012 Port: databuffer  output  17  bit16 = ten-thousands digit (0/1); [15:12],[11:8],[7:4],[3:0] = BCD digits.
REQ-013 Port: i  output  3  cursor digit index 0..4 (0 = [3:0], 4 = bit16).
REQ-014 Port: blink  output  1  cursor blink phase; 1 = digit visible.
REQ-015 Port: guess_valid  output  1  guess request to judge; guess value is databuffer.
REQ-016 Port: tries  output  4  wrong guesses so far.
REQ-017 Port: win  output  1  high in WIN state.
REQ-018 Port: lose  output  1  high in LOSE state.

Function
REQ-019 States EDIT, REQ, WIN, LOSE; reset state EDIT.
REQ-020 EDIT: at most one button acts per cycle; priority submit > inc > dec > left > right; lower-priority pulses in same cycle are discarded.
REQ-021 btn_left: i <= (i==4) ? 0 : i+1; btn_right: i <= (i==0) ? 4 : i-1; databuffer unchanged.
REQ-022 btn_inc, i in 0..3: selected BCD digit 9 -> 0, else +1; no carry into other digits.
REQ-023 btn_dec, i in 0..3: selected digit 0 -> 9, else -1; no borrow.
REQ-024 btn_inc or btn_dec with i==4: bit16 toggles.
REQ-025 btn_submit in EDIT: next cycle state REQ, guess_valid = 1; databuffer and i frozen.
REQ-026 REQ: guess_valid held 1 until result_valid sampled 1; all buttons ignored; no timeout.
REQ-027 REQ with result_valid=1 and result=10: next cycle state WIN, guess_valid = 0, tries unchanged.
REQ-028 REQ with result_valid=1 and result!=10: tries+1; if new tries == MAX_TRIES then LOSE, else EDIT; guess_valid = 0 next cycle; databuffer retained for editing.
REQ-029 result_valid outside REQ is ignored; no state or output change.
REQ-030 WIN/LOSE: inc/dec/left/right ignored; btn_submit -> EDIT with databuffer = 0, i = 0, tries = 0.
REQ-031 win = 1 exactly in WIN, lose = 1 exactly in LOSE; guess_valid = 1 exactly in REQ.
REQ-032 Blink counter free-runs 0..2*BLINK_HALF-1 then wraps to 0, in all states; blink = 1 when counter >= BLINK_HALF, else 0.
REQ-033 Blink counter restarts at 0 (blink = 0) on any accepted cursor move, increment or decrement, so the edited digit is blanked for one full half-period before showing.
REQ-034 All outputs registered; button response visible in the cycle after the pulse.

Reset
REQ-035 RST=1 at a clock edge: state EDIT, databuffer = 0, i = 0, tries = 0, blink counter = 0, blink = 0, guess_valid = 0, win = 0, lose = 0.
REQ-036 RST overrides all inputs the same cycle, including mid-REQ; a result_valid coincident with RST is discarded.

Verification
REQ-037 Reset, 3x btn_inc, btn_left, 2x btn_dec -> databuffer = 0x00083, i = 1.
REQ-038 i=4: 2x btn_left -> i = 1; from i=0: btn_right -> i = 4; btn_inc at i=4 twice -> bit16 1 then 0.
REQ-039 btn_submit -> guess_valid = 1 next cycle, held 5 cycles with buttons toggling (databuffer stable); result_valid=1, result=10 -> win = 1, guess_valid = 0.
REQ-040 MAX_TRIES=2: two submits answered result=00 -> tries 1 then state LOSE, lose = 1; btn_submit -> EDIT, databuffer = 0, tries = 0.
REQ-041 BLINK_HALF=4: blink 0 for 4 cycles, 1 for 4 cycles, repeating; btn_inc mid-high-phase -> blink = 0 next cycle, returns to 1 after 4 cycles.
REQ-042 btn_submit and btn_inc same cycle -> REQ entered, digit unchanged; RST asserted in REQ -> EDIT, guess_valid = 0, all outputs at reset values.
